// File: rtl/vscale_fregfile_sb.sv
// FP register file: two logical write ports over one physical port, a one-entry skid for the
// long-latency port, a write-pending scoreboard. Define VSCALE_FREGFILE_CLEAR_EN for the clear sequencer.
module vscale_fregfile_sb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    ra3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] rd3,
    output logic             busy1,
    output logic             busy2,
    output logic             busy3,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_wa,
    input  logic             wen0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             wen1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    output logic             wr1_ready,
    output logic             ready
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;

`ifdef VSCALE_FREGFILE_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e        state_q;
    logic [AW-1:0] clr_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_q <= StRun;
            end
        end
    end

    assign ready    = reset_n && (state_q == StRun);
    assign clr_we   = reset_n && (state_q == StClear);
    assign clr_addr = clr_cnt_q;
`else
    logic run_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign ready    = reset_n && run_q;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    logic             skid_valid_q;
    logic [AW-1:0]    skid_wa_q;
    logic [WIDTH-1:0] skid_wd_q;

    logic p0_we;
    logic p1_acc;
    logic p1_direct;
    logic skid_capture;
    logic skid_drain;
    logic skid_cancel;

    assign wr1_ready = ready && !skid_valid_q;

    always_comb begin
        p0_we        = ready && wen0;
        p1_acc       = wen1 && wr1_ready;
        p1_direct    = p1_acc && !p0_we;
        skid_capture = p1_acc && p0_we;
        skid_drain   = ready && skid_valid_q && !p0_we;
        // A port-0 write to the skid address supersedes the older long-latency value.
        skid_cancel  = skid_valid_q && p0_we && (wa0 == skid_wa_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
        end else if (skid_capture) begin
            skid_valid_q <= 1'b1;
            skid_wa_q    <= wa1;
            skid_wd_q    <= wd1;
        end else if (skid_drain || skid_cancel) begin
            skid_valid_q <= 1'b0;
        end
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (clr_we) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
        end else if (p0_we) begin
            mem_we = 1'b1;
            mem_wa = wa0;
            mem_wd = wd0;
        end else if (skid_drain) begin
            mem_we = 1'b1;
            mem_wa = skid_wa_q;
            mem_wd = skid_wd_q;
        end else if (p1_direct) begin
            mem_we = 1'b1;
            mem_wa = wa1;
            mem_wd = wd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_clr;
    logic [DEPTH-1:0] busy_set;
    logic [DEPTH-1:0] busy_vis;

    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (skid_drain || skid_cancel) begin
            busy_clr[skid_wa_q] = 1'b1;
        end
        if (p1_direct) begin
            busy_clr[wa1] = 1'b1;
        end
        if (ready && issue_valid) begin
            busy_set[issue_wa] = 1'b1;
        end
    end

    assign busy_vis = busy_q & ~busy_clr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_vis | busy_set;
        end
    end

    logic [AW-1:0]    ra_arr [3];
    logic [WIDTH-1:0] rd_arr [3];
    logic             bz_arr [3];

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;
    assign ra_arr[2] = ra3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bz_arr[i] = ready && busy_vis[ra_arr[i]];
            if (!ready) begin
                rd_arr[i] = '0;
            end else if (p0_we && (wa0 == ra_arr[i])) begin
                rd_arr[i] = wd0;
            end else if (skid_valid_q && (skid_wa_q == ra_arr[i])) begin
                rd_arr[i] = skid_wd_q;
            end else if (p1_direct && (wa1 == ra_arr[i])) begin
                rd_arr[i] = wd1;
            end else begin
                rd_arr[i] = mem_q[ra_arr[i]];
            end
        end
    end

    assign rd1   = rd_arr[0];
    assign rd2   = rd_arr[1];
    assign rd3   = rd_arr[2];
    assign busy1 = bz_arr[0];
    assign busy2 = bz_arr[1];
    assign busy3 = bz_arr[2];

endmodule

// File: tb/tb_vscale_fregfile_sb.sv
// Bench for vscale_fregfile_sb: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array/queue-level reference model.
module tb_vscale_fregfile_sb;

    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;
`ifdef VSCALE_FREGFILE_CLEAR_EN
    localparam int RDY_LAT = D;
`else
    localparam int RDY_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [A-1:0] ra1, ra2, ra3;
    logic [W-1:0] rd1, rd2, rd3;
    logic         busy1, busy2, busy3;
    logic         issue_valid;
    logic [A-1:0] issue_wa;
    logic         wen0, wen1;
    logic [A-1:0] wa0, wa1;
    logic [W-1:0] wd0, wd1;
    logic         wr1_ready, ready;

    always #5 clk = ~clk;

    vscale_fregfile_sb #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ra1        (ra1),
        .ra2        (ra2),
        .ra3        (ra3),
        .rd1        (rd1),
        .rd2        (rd2),
        .rd3        (rd3),
        .busy1      (busy1),
        .busy2      (busy2),
        .busy3      (busy3),
        .issue_valid(issue_valid),
        .issue_wa   (issue_wa),
        .wen0       (wen0),
        .wa0        (wa0),
        .wd0        (wd0),
        .wen1       (wen1),
        .wa1        (wa1),
        .wd1        (wd1),
        .wr1_ready  (wr1_ready),
        .ready      (ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents, which of them are defined, pending bits, skid entry.
    logic [W-1:0] m_mem [D];
    bit           m_known [D];
    bit           m_busy [D];
    bit           m_skv;
    logic [A-1:0] m_ska;
    logic [W-1:0] m_skd;
    bit           m_init = 1'b0;
    int           m_since = 0;

    function automatic bit m_ready();
        return reset_n && m_init && (m_since >= RDY_LAT);
    endfunction

    task automatic m_write(input logic [A-1:0] a, input logic [W-1:0] v);
        m_mem[a]   = v;
        m_known[a] = 1'b1;
    endtask

    task automatic model_step();
        bit cancel, drain, direct, capture;
        if (!reset_n) begin
            m_init  = 1'b1;
            m_since = 0;
            m_skv   = 1'b0;
            for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
            return;
        end
        if (!m_init) return;
        if (m_since < RDY_LAT) begin
            m_since++;
`ifdef VSCALE_FREGFILE_CLEAR_EN
            if (m_since == D) begin
                for (int i = 0; i < D; i++) m_write(i[A-1:0], '0);
            end
`endif
            return;
        end
        cancel  = m_skv && wen0 && (wa0 == m_ska);
        drain   = m_skv && !wen0;
        direct  = !m_skv && wen1 && !wen0;
        capture = !m_skv && wen1 && wen0;
        if (drain) m_write(m_ska, m_skd);
        if (cancel || drain) begin
            m_busy[m_ska] = 1'b0;
            m_skv = 1'b0;
        end
        if (wen0) m_write(wa0, wd0);
        if (direct) begin
            m_write(wa1, wd1);
            m_busy[wa1] = 1'b0;
        end
        if (capture) begin
            m_skv = 1'b1;
            m_ska = wa1;
            m_skd = wd1;
        end
        if (issue_valid) m_busy[issue_wa] = 1'b1;
    endtask

    task automatic exp_read(input logic [A-1:0] ra, output logic [W-1:0] v, output bit k);
        k = 1'b1;
        v = '0;
        if (!m_ready()) return;
        if (wen0 && wa0 == ra) v = wd0;
        else if (m_skv && m_ska == ra) v = m_skd;
        else if (!m_skv && wen1 && !wen0 && wa1 == ra) v = wd1;
        else begin
            v = m_mem[ra];
            k = m_known[ra];
        end
    endtask

    function automatic bit exp_busy(input logic [A-1:0] ra);
        bit clr;
        if (!m_ready()) return 1'b0;
        clr = (m_skv && (!wen0 || wa0 == m_ska) && m_ska == ra) ||
              (!m_skv && wen1 && !wen0 && wa1 == ra);
        return m_busy[ra] && !clr;
    endfunction

    task automatic compare_outputs();
        logic [W-1:0] v;
        bit           k;
        bit           rdy;
        rdy = m_ready();
        check("ready", {31'b0, ready}, {31'b0, rdy});
        check("wr1_ready", {31'b0, wr1_ready}, {31'b0, rdy && !m_skv});
        check("busy1", {31'b0, busy1}, {31'b0, exp_busy(ra1)});
        check("busy2", {31'b0, busy2}, {31'b0, exp_busy(ra2)});
        check("busy3", {31'b0, busy3}, {31'b0, exp_busy(ra3)});
        exp_read(ra1, v, k);
        if (k) check("rd1", rd1, v);
        exp_read(ra2, v, k);
        if (k) check("rd2", rd2, v);
        exp_read(ra3, v, k);
        if (k) check("rd3", rd3, v);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_init) compare_outputs();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0;
        wen1 = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ra1 = '0; ra2 = '0; ra3 = '0;
        issue_wa = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        idle();
        tick();
        tick();

        // Release reset with port 0 hammering register 0; nothing may land before ready.
        reset_n = 1'b1;
        wen0 = 1'b1;
        wa0 = 5'd0;
        wd0 = 32'hDEADBEEF;
        for (int i = 0; i < RDY_LAT; i++) begin
            #2 check("ready_low", {31'b0, ready}, 32'd0);
            tick();
        end
        wen0 = 1'b0;
        #2 check("ready_high", {31'b0, ready}, 32'd1);
`ifdef VSCALE_FREGFILE_CLEAR_EN
        for (int i = 0; i < D; i++) begin
            tick();
            ra1 = i[A-1:0];
            #2 check("cleared", rd1, 32'd0);
        end
`endif

        // Port-0 write forwards the same cycle, then reads from the array.
        tick();
        wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3F800000; ra1 = 5'd3;
        #2 check("p0_fwd", rd1, 32'h3F800000);
        tick();
        wen0 = 1'b0;
        #2 check("p0_array", rd1, 32'h3F800000);

        // Port-1 behind port 0 goes through the skid.
        tick();
        wen0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111;
        wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'hAAAA5555;
        #2 check("skid_accept", {31'b0, wr1_ready}, 32'd1);
        tick();
        wen1 = 1'b0; ra2 = 5'd7;
        #2 check("skid_full", {31'b0, wr1_ready}, 32'd0);
        check("skid_fwd", rd2, 32'hAAAA5555);
        tick();
        wen0 = 1'b0;
        #2 check("skid_drain_fwd", rd2, 32'hAAAA5555);
        tick();
        #2 check("skid_free", {31'b0, wr1_ready}, 32'd1);
        check("skid_array", rd2, 32'hAAAA5555);

        // Scoreboard set/clear, including set winning over a same-cycle clear.
        tick();
        ra1 = 5'd9; issue_valid = 1'b1; issue_wa = 5'd9;
        #2 check("busy_not_yet", {31'b0, busy1}, 32'd0);
        tick();
        issue_valid = 1'b0;
        #2 check("busy_set", {31'b0, busy1}, 32'd1);
        tick();
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h12345678; issue_valid = 1'b1;
        #2 check("busy_clr_now", {31'b0, busy1}, 32'd0);
        check("p1_direct_fwd", rd1, 32'h12345678);
        tick();
        wen1 = 1'b0; issue_valid = 1'b0;
        #2 check("busy_set_wins", {31'b0, busy1}, 32'd1);
        tick();
        wen1 = 1'b1; wd1 = 32'h0F0F0F0F;
        tick();
        wen1 = 1'b0;
        #2 check("busy_cleared", {31'b0, busy1}, 32'd0);
        check("p1_array", rd1, 32'h0F0F0F0F);

        // Skid entry superseded by a port-0 write to the same register.
        tick();
        issue_valid = 1'b1; issue_wa = 5'd4; ra3 = 5'd4;
        tick();
        issue_valid = 1'b0;
        wen0 = 1'b1; wa0 = 5'd10; wd0 = 32'h22222222;
        wen1 = 1'b1; wa1 = 5'd4; wd1 = 32'hBBBBBBBB;
        #2 check("busy4_set", {31'b0, busy3}, 32'd1);
        tick();
        wen1 = 1'b0; wa0 = 5'd4; wd0 = 32'h00000001; ra1 = 5'd4;
        #2 check("cancel_fwd", rd1, 32'h00000001);
        check("cancel_busy", {31'b0, busy3}, 32'd0);
        tick();
        wen0 = 1'b0;
        #2 check("cancel_free", {31'b0, wr1_ready}, 32'd1);
        check("cancel_keep", rd1, 32'h00000001);
        tick();
        #2 check("cancel_keep2", rd1, 32'h00000001);

        // Reset while the skid holds a value and a busy bit is pending.
        tick();
        issue_valid = 1'b1; issue_wa = 5'd2; ra2 = 5'd2;
        tick();
        issue_valid = 1'b0;
        wen0 = 1'b1; wa0 = 5'd11; wd0 = 32'h33333333;
        wen1 = 1'b1; wa1 = 5'd12; wd1 = 32'hCCCCCCCC;
        tick();
        wen1 = 1'b0;
        #2 check("pre_rst_skid", {31'b0, wr1_ready}, 32'd0);
        check("pre_rst_busy", {31'b0, busy2}, 32'd1);
        reset_n = 1'b0;
        wen0 = 1'b0;
        tick();
        reset_n = 1'b1;
        #2 check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy", {31'b0, busy2}, 32'd0);
        for (int i = 0; i < RDY_LAT; i++) tick();
        #2 check("rerun_ready", {31'b0, ready}, 32'd1);
        check("rerun_skid", {31'b0, wr1_ready}, 32'd1);
        check("rerun_busy", {31'b0, busy2}, 32'd0);
`ifdef VSCALE_FREGFILE_CLEAR_EN
        check("rerun_zero", rd1, 32'd0);
`endif

        // Random traffic with address collisions and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset_n     = ($urandom_range(0, 399) != 0);
            wen0        = 1'($urandom_range(0, 1));
            wen1        = 1'($urandom_range(0, 1));
            issue_valid = ($urandom_range(0, 9) < 3);
            wa0         = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
            wa1         = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
            issue_wa    = A'($urandom_range(0, 7));
            ra1         = A'($urandom_range(0, 7));
            ra2         = A'($urandom_range(0, 7));
            ra3         = A'($urandom);
            wd0         = $urandom;
            wd1         = $urandom;
        end
        tick();
        reset_n = 1'b1;
        idle();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
